ofdm_channel_equalizer_trained: RTL
===================================

# ofdm_channel_equalizer_trained

Per-subcarrier OFDM channel equalizer on Avalon-ST, next generation of the pass-through truncating equalizer. The first symbol of every packet is a training symbol whose received values are stored as channel estimates H[k]. Every following data beat is multiplied by conj(H[k]), then rounded, scaled and saturated to the output width. A bypass mode keeps the legacy truncate-only behaviour. Sits between the FFT output and the demapper.

## Interface
Parameters:
- IN_W, 17: signed width of each input I/Q component.
- OUT_W, 16: signed width of each output I/Q component.
- NSC, 64: subcarriers (beats) per symbol; power of two, ≥2.
- SHIFT, 16: right shift applied to the complex product before saturation.

Ports (data packing is I in the upper half, Q in the lower half):
- clock_clk  in  1  single clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- asi_in0_data  in  2*IN_W  received subcarrier.
- asi_in0_valid  in  1  input beat valid.
- asi_in0_ready  out  1  input beat accepted when valid & ready.
- asi_in0_startofpacket  in  1  marks the first beat of a packet (training k=0).
- asi_in0_endofpacket  in  1  marks the last beat of a packet.
- aso_out0_data  out  2*OUT_W  equalized subcarrier.
- aso_out0_valid  out  1  output beat valid.
- aso_out0_ready  in  1  downstream can accept.
- aso_out0_startofpacket  out  1  marks the first data beat of the packet.
- aso_out0_endofpacket  out  1  marks the last beat of the packet.
- cfg_bypass  in  1  1 = truncate-only mode; change it only while the block is idle.
- cfg_clr_err  in  1  synchronous clear of stat_err; a new error in the same cycle wins.
- stat_err  out  1  sticky protocol-error flag.

## Operation
- Subcarrier counter k, log2(NSC) bits:
  - increments on each accepted beat and wraps from NSC-1 to 0;
  - reset to 0 by an accepted SOP.
- FSM states: IDLE, TRAIN, DATA.
  - IDLE, SOP accepted: write beat to H[0], go to TRAIN.
  - IDLE, non-SOP beat accepted: drop it, set err.
  - TRAIN: each accepted beat writes H[k]; nothing is emitted. When k=NSC-1 is accepted, go to DATA.
  - TRAIN, EOP accepted: go to IDLE, set err.
  - DATA: each accepted beat is emitted equalized. The first DATA beat of the packet carries output SOP.
  - DATA, EOP accepted: emit it with output EOP, go to IDLE. If k≠NSC-1 at that point (short symbol), also set err.
  - SOP accepted in TRAIN or DATA: abort the current packet (no EOP is emitted for it), set err, restart TRAIN with this beat as H[0].
- Equalization arithmetic:
  - re = Yr·Hr + Yi·Hi; im = Yi·Hr − Yr·Hi; full precision 2*IN_W+1 bits.
  - Add 2^(SHIFT−1) (round half up), then arithmetic shift right by SHIFT.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Bypass mode:
  - FSM held in IDLE; every accepted beat is emitted.
  - Output I/Q = top OUT_W bits of the input I/Q (truncation, no rounding).
  - SOP and EOP pass through unchanged; the coefficient RAM is untouched.
- Coefficient RAM: NSC×2*IN_W, synchronous read; contents are not reset.
- stat_err is set by any error listed above and held until cfg_clr_err.

## Timing
- Two-stage pipeline:
  - S1 registers the beat, its flags and the H[k] read.
  - S2 registers the multiply/round/saturate result.
- Data beat accepted at cycle t appears on aso_out0 at t+2 when there is no stall.
- Global advance enable en = ~aso_out0_valid | aso_out0_ready.
  - asi_in0_ready = en.
  - Both stages move only on en; throughput is 1 beat/cycle.
- Training and dropped beats enter S1 as bubbles (valid=0).
- Output data, valid, SOP and EOP are stable while valid=1 and ready=0.
- A training write to H[k] and a data read of H[j] in the same cycle cannot collide: they belong to different symbols, and the read is captured at acceptance.
- Reset values:
  - all valids and SOP/EOP 0;
  - aso_out0_data 0;
  - state IDLE, k=0, stat_err 0;
  - asi_in0_ready goes to 1 right after reset.
- Reset mid-packet discards in-flight beats; the next packet must begin with SOP.

## Structure
- Package ofdm_eq_pkg holds:
  - the FSM state encoding;
  - I/Q field slice helpers;
  - the saturation-limit constants derived from OUT_W.
- Sub-module ofdm_eq_cmul: complex multiply by conjugate, round, shift and saturate. It is purely combinational; the parent owns all registers.
- Coefficient RAM is inferred in the top level, with no vendor primitive.

## Test plan
Bench parameters: NSC=4, IN_W=17, OUT_W=16, SHIFT=16.
- **Basic equalization.** Training on all four subcarriers = (1000,0), then data (2000,500) ×4 with EOP on the last beat → four outputs of (31,8). SOP on the first output, EOP on the fourth, latency 2.
- **Saturation.** H=(65535,0), Y=(65535,65535) → output (32767,32767). H=(65535,0), Y=(−65536,0) → output (−32768,0).
- **Backpressure.** aso_out0_ready low for 5 cycles mid-symbol → no beat lost or duplicated, output held stable, asi_in0_ready low while stalled.
- **Protocol errors.**
  - EOP on training beat 2 → nothing emitted, stat_err=1.
  - cfg_clr_err → stat_err=0.
  - SOP in DATA → restart, no EOP emitted for the aborted packet, stat_err=1.
- **Bypass.** cfg_bypass=1, input I=17'h12345 → output I=16'h91A2 after 2 cycles; SOP/EOP pass unchanged; no training symbol consumed.
- **Reset mid-packet.** Assert reset_reset_n low during DATA → all outputs 0 immediately. After release, a non-SOP beat is dropped and sets stat_err.

Source files
------------

// File: rtl/ofdm_eq_pkg.sv
`default_nettype none
// ============================================================================
// ofdm_eq_pkg : equalizer FSM encoding, I/Q field helpers, saturation limits
// Revision    : 1.0
// ============================================================================
package ofdm_eq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_TRAIN = 2'd1;
  localparam state_t ST_DATA  = 2'd2;

  // Beats pack I in the upper half and Q in the lower half, each w bits wide.
  function automatic logic [63:0] iq_hi(input logic [63:0] v, input int w);
    return (v >> w) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] iq_lo(input logic [63:0] v, input int w);
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_eq_cmul.sv
`default_nettype none
// ============================================================================
// ofdm_eq_cmul : Y * conj(H), round half up, arithmetic shift, saturate
// Revision     : 1.0
// ============================================================================
module ofdm_eq_cmul
  import ofdm_eq_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  y_i,
  input  logic signed [IN_W-1:0]  y_q,
  input  logic signed [IN_W-1:0]  h_i,
  input  logic signed [IN_W-1:0]  h_q,
  output logic signed [OUT_W-1:0] z_i,
  output logic signed [OUT_W-1:0] z_q
);

  // One guard bit beyond full precision so the rounding add cannot wrap.
  localparam int PW = 2 * IN_W + 2;
  localparam logic signed [PW-1:0] RND  = PW'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(sat_max(OUT_W));
  localparam logic signed [PW-1:0] MINV = PW'(sat_min(OUT_W));

  logic signed [PW-1:0] yi_x, yq_x, hi_x, hq_x;
  logic signed [PW-1:0] re, im, re_s, im_s;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV) return MAXV[OUT_W-1:0];
    if (v < MINV) return MINV[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  always_comb begin
    yi_x = PW'(y_i);
    yq_x = PW'(y_q);
    hi_x = PW'(h_i);
    hq_x = PW'(h_q);
    re   = yi_x * hi_x + yq_x * hq_x;
    im   = yq_x * hi_x - yi_x * hq_x;
    re_s = (re + RND) >>> SHIFT;
    im_s = (im + RND) >>> SHIFT;
    z_i  = sat(re_s);
    z_q  = sat(im_s);
  end

endmodule
`default_nettype wire

// File: rtl/ofdm_channel_equalizer_trained.sv
`default_nettype none
// ============================================================================
// ofdm_channel_equalizer_trained : trained per-subcarrier equalizer, Avalon-ST
// Revision                       : 1.0
// ============================================================================
module ofdm_channel_equalizer_trained
  import ofdm_eq_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int NSC   = 64,
  parameter int SHIFT = 16
) (
  input  logic                 clock_clk,
  input  logic                 reset_reset_n,
  input  logic [2*IN_W-1:0]    asi_in0_data,
  input  logic                 asi_in0_valid,
  output logic                 asi_in0_ready,
  input  logic                 asi_in0_startofpacket,
  input  logic                 asi_in0_endofpacket,
  output logic [2*OUT_W-1:0]   aso_out0_data,
  output logic                 aso_out0_valid,
  input  logic                 aso_out0_ready,
  output logic                 aso_out0_startofpacket,
  output logic                 aso_out0_endofpacket,
  input  logic                 cfg_bypass,
  input  logic                 cfg_clr_err,
  output logic                 stat_err
);

  localparam int KW = (NSC > 1) ? $clog2(NSC) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSC - 1);

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               err_q, err_d;
  logic               first_q, first_d;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sop_q, s1_sop_d;
  logic               s1_eop_q, s1_eop_d;
  logic               s1_byp_q, s1_byp_d;
  logic [2*IN_W-1:0]  s1_y_q, s1_y_d;
  logic [2*IN_W-1:0]  h_q, h_d;

  logic               out_valid_q, out_valid_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [2*OUT_W-1:0] out_data_q, out_data_d;

  logic [2*IN_W-1:0]  coef_mem [NSC];

  logic               en, acc, sop, eop;
  logic               ram_we, emit, emit_sop, emit_eop, err_set;
  logic [KW-1:0]      ram_waddr;

  logic signed [IN_W-1:0]  y_i, y_q, hc_i, hc_q;
  logic signed [OUT_W-1:0] z_i, z_q;
  logic [OUT_W-1:0]        byp_i, byp_q;

  assign en  = ~out_valid_q | aso_out0_ready;
  assign acc = asi_in0_valid & en;
  assign sop = asi_in0_startofpacket;
  assign eop = asi_in0_endofpacket;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (cfg_bypass) begin
      state_d = ST_IDLE;
    end else if (acc) begin
      case (state_q)
        ST_IDLE:  if (sop) state_d = ST_TRAIN;
        ST_TRAIN: begin
          if (sop)                 state_d = ST_TRAIN;
          else if (eop)            state_d = ST_IDLE;
          else if (k_q == K_LAST)  state_d = ST_DATA;
        end
        ST_DATA: begin
          if (sop)      state_d = ST_TRAIN;
          else if (eop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = sop ? '0 : k_q;
    emit      = 1'b0;
    emit_sop  = 1'b0;
    emit_eop  = 1'b0;
    err_set   = 1'b0;
    first_d   = first_q;
    if (cfg_bypass) begin
      emit     = acc;
      emit_sop = sop;
      emit_eop = eop;
    end else if (acc) begin
      case (state_q)
        ST_IDLE: begin
          if (sop) ram_we  = 1'b1;
          else     err_set = 1'b1;
        end
        ST_TRAIN: begin
          ram_we = 1'b1;
          if (sop || eop)          err_set = 1'b1;
          else if (k_q == K_LAST)  first_d = 1'b1;
        end
        ST_DATA: begin
          if (sop) begin
            ram_we  = 1'b1;
            err_set = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_sop = first_q;
            first_d  = 1'b0;
            if (eop) begin
              emit_eop = 1'b1;
              if (k_q != K_LAST) err_set = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- counter, error flag, pipeline ----------------
  assign y_i   = IN_W'(iq_hi(64'(s1_y_q), IN_W));
  assign y_q   = IN_W'(iq_lo(64'(s1_y_q), IN_W));
  assign hc_i  = IN_W'(iq_hi(64'(h_q), IN_W));
  assign hc_q  = IN_W'(iq_lo(64'(h_q), IN_W));
  assign byp_i = OUT_W'(iq_hi(64'(s1_y_q), IN_W) >> (IN_W - OUT_W));
  assign byp_q = OUT_W'(iq_lo(64'(s1_y_q), IN_W) >> (IN_W - OUT_W));

  ofdm_eq_cmul #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_cmul (
    .y_i (y_i),
    .y_q (y_q),
    .h_i (hc_i),
    .h_q (hc_q),
    .z_i (z_i),
    .z_q (z_q)
  );

  always_comb begin
    k_d         = k_q;
    s1_valid_d  = s1_valid_q;
    s1_sop_d    = s1_sop_q;
    s1_eop_d    = s1_eop_q;
    s1_byp_d    = s1_byp_q;
    s1_y_d      = s1_y_q;
    h_d         = h_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    if (acc) k_d = sop ? KW'(1) : k_q + KW'(1);
    // A new error in the same cycle as a clear must win.
    err_d = err_set ? 1'b1 : (cfg_clr_err ? 1'b0 : err_q);
    if (en) begin
      s1_valid_d  = emit;
      s1_sop_d    = emit_sop;
      s1_eop_d    = emit_eop;
      s1_byp_d    = cfg_bypass;
      s1_y_d      = asi_in0_data;
      h_d         = coef_mem[k_q];
      out_valid_d = s1_valid_q;
      out_sop_d   = s1_valid_q & s1_sop_q;
      out_eop_d   = s1_valid_q & s1_eop_q;
      if (s1_valid_q) out_data_d = s1_byp_q ? {byp_i, byp_q} : {z_i, z_q};
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      k_q         <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_y_q      <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      k_q         <= k_d;
      err_q       <= err_d;
      first_q     <= first_d;
      s1_valid_q  <= s1_valid_d;
      s1_sop_q    <= s1_sop_d;
      s1_eop_q    <= s1_eop_d;
      s1_byp_q    <= s1_byp_d;
      s1_y_q      <= s1_y_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
    end
  end

  // Coefficient storage and its read register carry no reset.
  always_ff @(posedge clock_clk) begin
    if (ram_we) coef_mem[ram_waddr] <= asi_in0_data;
    h_q <= h_d;
  end

  assign asi_in0_ready          = en;
  assign aso_out0_data          = out_data_q;
  assign aso_out0_valid         = out_valid_q;
  assign aso_out0_startofpacket = out_sop_q;
  assign aso_out0_endofpacket   = out_eop_q;
  assign stat_err               = err_q;

endmodule
`default_nettype wire
